// File: rtl/bomb_countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bomb_countdown_ctrl
// Brief    : Countdown sequencer for the bomb game. Holds the remaining time
//            in binary seconds, applies strike penalties, counts strikes and
//            decides DEFUSED / EXPLODED. Exposes BCD digits for the display.
// Revision : 1.0 - initial release
// ============================================================================
module bomb_countdown_ctrl #(
  parameter int START_MIN   = 5,
  parameter int START_SEC   = 0,
  parameter int PENALTY_SEC = 10,
  parameter int MAX_STRIKES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       arm,
  input  logic       pause,
  input  logic       strike,
  input  logic       defuse,
  output logic       timer_run,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] strikes,
  output logic       armed,
  output logic       defused,
  output logic       exploded
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_PAUSED   = 3'd2,
    S_DEFUSED  = 3'd3,
    S_EXPLODED = 3'd4
  } state_t;

  localparam logic [12:0] C_LOAD        = 13'(START_MIN * 60 + START_SEC);
  localparam logic [12:0] C_PENALTY     = 13'(PENALTY_SEC);
  localparam logic [1:0]  C_MAX_STRIKES = 2'(MAX_STRIKES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [12:0] r_remain;
  logic [12:0] w_remain_nxt;
  logic [1:0]  r_strikes;
  logic [1:0]  w_strikes_nxt;
  logic [12:0] w_dec;
  logic [1:0]  w_strikes_inc;
  logic [6:0]  w_min;
  logic [5:0]  w_sec;

  // State, remaining time and strike count; reset reloads the start time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_remain  <= C_LOAD;
      r_strikes <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_remain  <= w_remain_nxt;
      r_strikes <= w_strikes_nxt;
    end
  end

  // Next state and datapath update; defuse wins, then explosion, then pause.
  always_comb begin
    w_state_nxt   = r_state;
    w_remain_nxt  = r_remain;
    w_strikes_nxt = r_strikes;
    // Ticks only count while running; a paused game still takes penalties.
    w_dec         = (strike ? C_PENALTY : 13'd0)
                  + ((r_state == S_ARMED && tick) ? 13'd1 : 13'd0);
    w_strikes_inc = (strike && r_strikes != 2'd3) ? r_strikes + 2'd1 : r_strikes;
    case (r_state)
      S_IDLE: begin
        if (arm) w_state_nxt = S_ARMED;
      end
      S_ARMED, S_PAUSED: begin
        if (defuse) begin
          w_state_nxt = S_DEFUSED;
        end else begin
          w_strikes_nxt = w_strikes_inc;
          if (w_dec >= r_remain) begin
            // Time ran out: clamp to zero rather than wrap.
            w_remain_nxt = 13'd0;
            w_state_nxt  = S_EXPLODED;
          end else if (w_strikes_inc >= C_MAX_STRIKES) begin
            // Strike limit freezes the clock where it was.
            w_state_nxt  = S_EXPLODED;
          end else begin
            w_remain_nxt = r_remain - w_dec;
            w_state_nxt  = pause ? S_PAUSED : S_ARMED;
          end
        end
      end
      S_DEFUSED, S_EXPLODED: begin
        if (arm) begin
          w_state_nxt   = S_IDLE;
          w_remain_nxt  = C_LOAD;
          w_strikes_nxt = 2'd0;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_remain_nxt  = C_LOAD;
        w_strikes_nxt = 2'd0;
      end
    endcase
  end

  // Binary seconds to MM:SS BCD for the display driver.
  assign w_min    = 7'(r_remain / 13'd60);
  assign w_sec    = 6'(r_remain % 13'd60);
  assign min_tens = 4'(w_min / 7'd10);
  assign min_ones = 4'(w_min % 7'd10);
  assign sec_tens = 4'(w_sec / 6'd10);
  assign sec_ones = 4'(w_sec % 6'd10);

  // Flags come straight from the registered state so they cannot glitch.
  assign timer_run = (r_state == S_ARMED);
  assign armed     = (r_state == S_ARMED);
  assign defused   = (r_state == S_DEFUSED);
  assign exploded  = (r_state == S_EXPLODED);
  assign strikes   = r_strikes;

endmodule
`default_nettype wire
